// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//
// AXI-Lite write-only initiator that programs the FIR filter's register slave
// from a local coefficient buffer. Local logic fills the buffer and then
// pulses `start`. The block then issues three kinds of write:
//   write 0      : CTRL  = {0, load=1, 22'b0, N}
//   writes 1..N  : COEFF = sign-extended buffer[i-1]
//   write N+1    : CTRL  = {enable=1, 0, 22'b0, N}
// The transfer ends with a one-cycle `done` pulse and a sticky error
// classification.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   coeff_we/waddr/wdata local buffer write port (ignored while busy)
//   tap_count, start    transfer request; tap_count is sampled with start
//   busy, done          transfer in progress / one-cycle completion pulse
//   error, err_code     sticky result: 0 none, 1 bad tap_count,
//                       2 BRESP not OKAY, 3 per-write timeout
//   m_axi_aw*/w*/b*     AXI-Lite write address, data and response channels
// -----------------------------------------------------------------------------
module fir_coeff_loader #(
  parameter int                    MAX_TAPS       = 16,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coeff_we,
  input  logic [$clog2(MAX_TAPS)-1:0] coeff_waddr,
  input  logic [15:0]                 coeff_wdata,
  input  logic [7:0]                  tap_count,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code,
  output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [DATA_WIDTH-1:0]       m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);

  localparam int IW = $clog2(MAX_TAPS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    WAIT_B    = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [15:0]           coeff_buf [MAX_TAPS];
  logic [7:0]            n_taps;     // tap count latched at start
  logic [8:0]            idx;        // current write number, 0..N+1
  logic                  aw_done;    // address handshake already taken
  logic                  w_done;     // data handshake already taken
  logic [CW-1:0]         cnt;        // cycles spent on the current write

  logic                  aw_hs, w_hs;
  logic                  bad_count, expired, last_write;
  logic                  start_ok, start_bad, next_beat, err_set;
  logic [1:0]            err_val;
  logic [15:0]           coeff_rd;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_data;

  assign m_axi_awprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;
  assign error        = (err_code != 2'd0);

  assign aw_hs      = (state == ADDR_DATA) && !aw_done && m_axi_awready;
  assign w_hs       = (state == ADDR_DATA) && !w_done  && m_axi_wready;
  assign bad_count  = (tap_count == 8'd0) || (int'(tap_count) > MAX_TAPS);
  assign expired    = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign last_write = (idx == ({1'b0, n_taps} + 9'd1));

  // Address/data of the write that follows the current one. Write idx+1 is
  // either coefficient buffer[idx] or, after the last coefficient, the commit.
  assign coeff_rd = coeff_buf[idx[IW-1:0]];

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    nxt_addr = BASE_ADDR + ADDR_WIDTH'(4);
    nxt_data = {{16{coeff_rd[15]}}, coeff_rd};
    if (idx == {1'b0, n_taps}) begin
      nxt_addr = BASE_ADDR;
      nxt_data = {1'b1, 1'b0, 22'b0, n_taps};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    start_ok      = 1'b0;
    start_bad     = 1'b0;
    next_beat     = 1'b0;
    err_set       = 1'b0;
    err_val       = 2'd0;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_count) begin
            state_nxt = DONE;
            start_bad = 1'b1;
          end else begin
            state_nxt = ADDR_DATA;
            start_ok  = 1'b1;
          end
        end
      end
      ADDR_DATA: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if (expired) begin
          state_nxt = DONE;
          err_set   = 1'b1;
          err_val   = 2'd3;
        end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            state_nxt = DONE;
            err_set   = 1'b1;
            err_val   = 2'd2;
          end else if (last_write) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ADDR_DATA;
            next_beat = 1'b1;
          end
        end else if (expired) begin
          // Abandoning an outstanding write is a deliberate recovery path:
          // the slave is presumed dead and bready is simply withdrawn.
          state_nxt = DONE;
          err_set   = 1'b1;
          err_val   = 2'd3;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer, write sequencing and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer is small and must read back as zero after reset, so
      // it is reset entry by entry rather than left as uninitialised RAM.
      for (int i = 0; i < MAX_TAPS; i++) coeff_buf[i] <= '0;
      n_taps       <= '0;
      idx          <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      cnt          <= '0;
      err_code     <= 2'd0;
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
    end else begin
      // Buffer writes land in IDLE only, so a write in the start cycle is
      // visible to the transfer (coefficients are read after write 0).
      if (coeff_we && (state == IDLE) && (int'(coeff_waddr) < MAX_TAPS))
        coeff_buf[coeff_waddr] <= coeff_wdata;

      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if ((state == ADDR_DATA) || (state == WAIT_B)) cnt <= cnt + CW'(1);

      if (start_ok) begin
        n_taps       <= tap_count;
        idx          <= '0;
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
        cnt          <= '0;
        err_code     <= 2'd0;
        m_axi_awaddr <= BASE_ADDR;
        m_axi_wdata  <= {1'b0, 1'b1, 22'b0, tap_count};
      end

      if (next_beat) begin
        idx          <= idx + 9'd1;
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
        cnt          <= '0;
        m_axi_awaddr <= nxt_addr;
        m_axi_wdata  <= nxt_data;
      end

      if (start_bad) err_code <= 2'd1;
      if (err_set)   err_code <= err_val;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
//
// Self-checking bench for fir_coeff_loader. A configurable AXI-Lite slave
// model answers the write channels; a behavioural model of the coefficient
// buffer and the write sequence supplies every expected value. A second
// instance with a short timeout exercises the abort path.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;

  localparam int          MAX_TAPS = 16;
  localparam logic [31:0] BASE     = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        coeff_we    = 1'b0;
  logic [3:0]  coeff_waddr = '0;
  logic [15:0] coeff_wdata = '0;
  logic [7:0]  tap_count   = '0;
  logic        start       = 1'b0;

  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready;
  logic        awready = 1'b0;
  logic        wready  = 1'b0;
  logic        bvalid  = 1'b0;
  logic [1:0]  bresp   = 2'b00;

  // Timeout instance: always-ready address/data, never responds on B.
  logic        start_to = 1'b0;
  logic        to_one   = 1'b1;
  logic        to_zero  = 1'b0;
  logic [1:0]  to_resp  = 2'b00;
  logic        to_busy, to_done, to_error, to_awvalid, to_wvalid, to_bready;
  logic [1:0]  to_err_code;
  logic [31:0] to_awaddr, to_wdata;
  logic [2:0]  to_awprot;
  logic [3:0]  to_wstrb;

  fir_coeff_loader #(.MAX_TAPS(MAX_TAPS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .coeff_we(coeff_we), .coeff_waddr(coeff_waddr), .coeff_wdata(coeff_wdata),
    .tap_count(tap_count), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  fir_coeff_loader #(.MAX_TAPS(MAX_TAPS), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst(rst),
    .coeff_we(coeff_we), .coeff_waddr(coeff_waddr), .coeff_wdata(coeff_wdata),
    .tap_count(tap_count), .start(start_to),
    .busy(to_busy), .done(to_done), .error(to_error), .err_code(to_err_code),
    .m_axi_awaddr(to_awaddr), .m_axi_awprot(to_awprot), .m_axi_awvalid(to_awvalid),
    .m_axi_awready(to_one),
    .m_axi_wdata(to_wdata), .m_axi_wstrb(to_wstrb), .m_axi_wvalid(to_wvalid),
    .m_axi_wready(to_one),
    .m_axi_bresp(to_resp), .m_axi_bvalid(to_zero), .m_axi_bready(to_bready)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: buffer contents and the write each beat should carry
  // ---------------------------------------------------------------------------
  logic [15:0] model_buf [MAX_TAPS];

  function automatic logic [63:0] exp_beat(input int i, input int n);
    if (i == 0)     return {BASE, 32'h4000_0000 | 32'(n)};
    if (i == n + 1) return {BASE, 32'h8000_0000 | 32'(n)};
    return {BASE + 32'd4, 32'($signed(model_buf[i-1]))};
  endfunction

  // ---------------------------------------------------------------------------
  // Slave model: ready/response latencies counted from valid/bready rising
  // ---------------------------------------------------------------------------
  int aw_lat = 0, w_lat = 0, b_lat = 0, err_at = 99;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int b_num  = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (bready) begin
        bvalid = (b_cnt >= b_lat);
        bresp  = (b_num == err_at) ? 2'b10 : 2'b00;
        b_cnt++;
      end else begin
        bvalid = 1'b0; bresp = 2'b00; b_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus monitor (falling edge): records handshakes, checks channel stability
  // ---------------------------------------------------------------------------
  logic [31:0] aw_q [$];
  logic [31:0] w_q  [$];
  bit          any_valid = 1'b0;
  logic        p_awv = 1'b0, p_awhs = 1'b0, p_wv = 1'b0, p_whs = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      p_awv = 1'b0; p_awhs = 1'b0; p_wv = 1'b0; p_whs = 1'b0;
    end else begin
      if (p_awv && !p_awhs) begin
        check("awvalid held until handshake", awvalid, 1'b1);
        check("awaddr stable while valid", awaddr, p_awaddr);
      end
      if (p_awhs) check("awvalid drops after its handshake", awvalid, 1'b0);
      if (p_wv && !p_whs) begin
        check("wvalid held until handshake", wvalid, 1'b1);
        check("wdata stable while valid", wdata, p_wdata);
      end
      if (p_whs) check("wvalid drops after its handshake", wvalid, 1'b0);
      if (awvalid && awready) begin
        aw_q.push_back(awaddr);
        check("awprot", awprot, 3'b000);
      end
      if (wvalid && wready) begin
        w_q.push_back(wdata);
        check("wstrb", wstrb, 4'hF);
      end
      if (bvalid && bready) b_num++;
      if (awvalid || wvalid) any_valid = 1'b1;
      p_awv = awvalid; p_awhs = awvalid && awready; p_awaddr = awaddr;
      p_wv  = wvalid;  p_whs  = wvalid && wready;   p_wdata  = wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic load_coeff(input int idx, input logic [15:0] val);
    @(negedge clk);
    coeff_we = 1'b1; coeff_waddr = 4'(idx); coeff_wdata = val;
    model_buf[idx] = val;
    @(negedge clk);
    coeff_we = 1'b0;
  endtask

  // One full transfer. x_lat = 0 skips the latency check. With noise set, a
  // buffer write accompanies start (must take effect) and random buffer
  // writes are issued while busy (must be ignored).
  task automatic run_txn(input int n, input int aw_l, input int w_l, input int b_l,
                         input int e_at, input int x_err, input int x_wr,
                         input int x_lat, input bit noise, input string tag);
    int          cyc;
    int          widx;
    logic [63:0] eb;
    @(negedge clk);
    aw_q.delete(); w_q.delete(); b_num = 0; any_valid = 1'b0;
    aw_lat = aw_l; w_lat = w_l; b_lat = b_l; err_at = e_at;
    tap_count = 8'(n);
    start     = 1'b1;
    if (noise) begin
      widx = $urandom_range(0, MAX_TAPS - 1);
      coeff_we = 1'b1; coeff_waddr = 4'(widx); coeff_wdata = 16'($urandom);
      model_buf[widx] = coeff_wdata;
    end
    @(negedge clk);
    cyc = 1;
    start = 1'b0; coeff_we = 1'b0;
    check({tag, " busy after start"}, busy, 1'b1);
    while (!done && cyc < 600) begin
      if (noise) begin
        coeff_we = $urandom_range(0, 1) == 1;
        coeff_waddr = 4'($urandom); coeff_wdata = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
      coeff_we = 1'b0;
    end
    check({tag, " done reached"}, done, 1'b1);
    if (x_lat != 0) check({tag, " done latency"}, cyc, x_lat);
    check({tag, " err_code"}, err_code, x_err);
    check({tag, " error"}, error, x_err != 0);
    check({tag, " aw count"}, aw_q.size(), x_wr);
    check({tag, " w count"}, w_q.size(), x_wr);
    if (x_wr == 0) check({tag, " no valid asserted"}, any_valid, 1'b0);
    for (int i = 0; i < x_wr; i++) begin
      eb = exp_beat(i, n);
      if (i < aw_q.size()) check($sformatf("%s awaddr[%0d]", tag, i), aw_q[i], eb[63:32]);
      if (i < w_q.size())  check($sformatf("%s wdata[%0d]", tag, i), w_q[i], eb[31:0]);
    end
    @(negedge clk);
    check({tag, " done one cycle"}, done, 1'b0);
    check({tag, " idle after done"}, busy, 1'b0);
    check({tag, " err_code sticky"}, err_code, x_err);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int n;
    int aw_l, w_l, b_l;
    int e_at;
    int x_err, x_wr, x_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n, aw_l, w_l, b_l, e_at, x_err, x_wr, x_lat, cyc;

    vecs[0] = '{4,   0, 0, 0, 99, 0, 6,  13};  // baseline, ready slave
    vecs[1] = '{4,   3, 0, 5, 99, 0, 6,  0};   // slow awready, late bvalid
    vecs[2] = '{0,   0, 0, 0, 99, 1, 0,  1};   // tap_count 0
    vecs[3] = '{17,  0, 0, 0, 99, 1, 0,  1};   // one above MAX_TAPS
    vecs[4] = '{4,   0, 0, 0, 2,  2, 3,  7};   // SLVERR on write 2
    vecs[5] = '{1,   0, 0, 0, 99, 0, 3,  7};   // clears the sticky error
    vecs[6] = '{16,  0, 0, 0, 99, 0, 18, 37};  // full buffer
    vecs[7] = '{255, 0, 0, 0, 99, 1, 0,  1};   // far out of range
    vecs[8] = '{16,  1, 2, 1, 17, 2, 18, 0};   // SLVERR on the commit write

    for (int i = 0; i < MAX_TAPS; i++) model_buf[i] = '0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("reset awvalid", awvalid, 1'b0);
    check("reset wvalid", wvalid, 1'b0);
    check("reset bready", bready, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset error", error, 1'b0);
    check("reset err_code", err_code, 2'd0);
    check("reset awaddr", awaddr, 32'h0);
    check("reset wdata", wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load_coeff(0, 16'h0001);
    load_coeff(1, 16'hFFFE);
    load_coeff(2, 16'h7FFF);
    load_coeff(3, 16'h8000);

    for (int v = 0; v < 9; v++)
      run_txn(vecs[v].n, vecs[v].aw_l, vecs[v].w_l, vecs[v].b_l, vecs[v].e_at,
              vecs[v].x_err, vecs[v].x_wr, vecs[v].x_lat, 1'b0,
              $sformatf("vec%0d", v));

    // Randomised transfers against the model
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 3; k++)
        load_coeff($urandom_range(0, MAX_TAPS - 1), 16'($urandom));
      n    = $urandom_range(0, 18);
      aw_l = $urandom_range(0, 3);
      w_l  = $urandom_range(0, 3);
      b_l  = $urandom_range(0, 3);
      e_at = $urandom_range(0, 30);
      if (n == 0 || n > MAX_TAPS) begin
        x_err = 1; x_wr = 0;
      end else if (e_at <= n + 1) begin
        x_err = 2; x_wr = e_at + 1;
      end else begin
        x_err = 0; x_wr = n + 2;
      end
      if (x_err == 1)                          x_lat = 1;
      else if (aw_l == 0 && w_l == 0 && b_l == 0) x_lat = 2 * x_wr + 1;
      else                                     x_lat = 0;
      run_txn(n, aw_l, w_l, b_l, e_at, x_err, x_wr, x_lat, 1'b1,
              $sformatf("rand%0d", r));
    end

    // Timeout: the slave never answers on B; 8-cycle limit per write
    @(negedge clk);
    tap_count = 8'd2;
    start_to  = 1'b1;
    @(negedge clk);
    start_to = 1'b0;
    check("to valids first cycle", to_awvalid && to_wvalid, 1'b1);
    for (cyc = 2; cyc <= 8; cyc++) begin
      @(negedge clk);
      check($sformatf("to bready cycle %0d", cyc), to_bready, 1'b1);
      check($sformatf("to no done cycle %0d", cyc), to_done, 1'b0);
    end
    @(negedge clk);
    check("to done pulse", to_done, 1'b1);
    check("to bready dropped", to_bready, 1'b0);
    check("to err_code", to_err_code, 2'd3);
    check("to error", to_error, 1'b1);
    @(negedge clk);
    check("to idle after done", to_busy, 1'b0);
    check("to err_code sticky", to_err_code, 2'd3);

    // Reset during write 1 (the first coefficient)
    @(negedge clk);
    aw_q.delete(); w_q.delete(); b_num = 0;
    aw_lat = 0; w_lat = 0; b_lat = 0; err_at = 99;
    tap_count = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(b_num == 1 && awvalid) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reached write 1", b_num == 1 && awvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid reset awvalid", awvalid, 1'b0);
    check("mid reset wvalid", wvalid, 1'b0);
    check("mid reset bready", bready, 1'b0);
    check("mid reset busy", busy, 1'b0);
    check("mid reset done", done, 1'b0);
    check("mid reset err_code", err_code, 2'd0);
    check("mid reset awaddr", awaddr, 32'h0);
    check("mid reset wdata", wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < MAX_TAPS; i++) model_buf[i] = '0;
    run_txn(4, 0, 0, 0, 99, 0, 6, 13, 1'b0, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
